// File: rtl/conv_engine_pkg.sv
// Shared types and arithmetic helpers for the convolution layer engine and its MAC lanes.
package conv_engine_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Wide enough for any accumulator plus bias the engine is expected to be built with.
    localparam int MAX_W = 64;

    function automatic int acc_width(input int width, input int taps);
        return 2 * width + $clog2(taps);
    endfunction

    // Drop the fractional bits, clamp into a signed width-bit range, optionally zero negatives.
    function automatic logic signed [MAX_W-1:0] rescale(input logic signed [MAX_W-1:0] r,
                                                        input int width,
                                                        input int frac,
                                                        input bit relu);
        logic signed [MAX_W-1:0] s;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        s  = r >>> frac;
        hi = (MAX_W'(1) <<< (width - 1)) - MAX_W'(1);
        lo = -(MAX_W'(1) <<< (width - 1));
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
        if (relu && s[MAX_W-1])
            s = '0;
        return s;
    endfunction

endpackage

// File: rtl/conv_layer_engine_if.sv
// Pixel stream, weight ROM, bias and result signals of the convolution layer engine.
interface conv_layer_engine_if #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 368,
    parameter int ADDR_W = 10
);
    logic                        start;
    logic signed [WIDTH-1:0]     ifm;
    logic                        ifm_valid;
    logic [ADDR_W-1:0]           weight_addr;
    logic [WIDTH*DSP_NO-1:0]     weights;
    logic [2*WIDTH*DSP_NO-1:0]   bias;
    logic [WIDTH*DSP_NO-1:0]     ofm;
    logic                        ofm_valid;
    logic                        busy;
    logic                        done;

    modport master (
        output start, ifm, ifm_valid, weights, bias,
        input  weight_addr, ofm, ofm_valid, busy, done
    );

    modport slave (
        input  start, ifm, ifm_valid, weights, bias,
        output weight_addr, ofm, ofm_valid, busy, done
    );
endinterface

// File: rtl/conv_mac_lane.sv
// One output channel: load-on-first multiply-accumulate, then bias, rescale, saturate and ReLU.
module conv_mac_lane
    import conv_engine_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 14,
    parameter int ACC_W     = 42,
    parameter int RELU_EN   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      beat,
    input  logic                      first,
    input  logic                      fin,
    input  logic signed [WIDTH-1:0]   ifm,
    input  logic signed [WIDTH-1:0]   weight,
    input  logic signed [2*WIDTH-1:0] bias,
    output logic [WIDTH-1:0]          ofm
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc;

    assign prod = (2*WIDTH)'(ifm) * (2*WIDTH)'(weight);

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (beat)
            acc <= first ? ACC_W'(prod) : acc + ACC_W'(prod);
    end

    // fin arrives one cycle after the last tap, while acc still holds the finished sum.
    always_ff @(posedge clk) begin
        if (rst)
            ofm <= '0;
        else if (fin)
            ofm <= WIDTH'(rescale(MAX_W'(acc) + MAX_W'(bias), WIDTH, FRAC_BITS, RELU_EN != 0));
    end

endmodule

// File: rtl/conv_layer_engine.sv
// Layer-agnostic convolution engine: sequences taps and pixels, aligns the pixel stream with the
// external weight ROM and broadcasts each aligned beat to DSP_NO MAC lanes.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | accepting taps while ifm_valid is high
//  DRAIN | all taps taken, waiting for the final output pixel
//  DONE  | one-cycle done pulse
module conv_layer_engine
    import conv_engine_pkg::*;
#(
    parameter int DSP_NO     = 368,
    parameter int CHIN       = 112,
    parameter int KERNEL_DIM = 3,
    parameter int WOUT       = 8,
    parameter int WIDTH      = 16,
    parameter int FRAC_BITS  = 14,
    parameter int RELU_EN    = 1
) (
    input logic                clk,
    input logic                rst,
    conv_layer_engine_if.slave bus
);

    localparam int TAPS  = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int ACC_W = acc_width(WIDTH, TAPS);
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int NPIX  = WOUT * WOUT;
    localparam int PIX_W = $clog2(NPIX + 1);

    state_t                  state, state_nxt;
    logic [TAP_W-1:0]        tap_cnt;
    logic [PIX_W-1:0]        pix_in, pix_out;
    logic                    beat, is_first, is_last;
    logic signed [WIDTH-1:0] ifm_d;
    logic                    vld_d, first_d, last_d, fin, ofm_valid_q;
    logic                    busy, done;
    logic [WIDTH-1:0]        ofm_lane [DSP_NO];
    logic [WIDTH*DSP_NO-1:0] ofm_pk;

    assign beat     = (state == RUN) && bus.ifm_valid;
    assign is_first = (tap_cnt == '0);
    assign is_last  = (tap_cnt == TAP_W'(TAPS - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (beat && is_last && pix_in == PIX_W'(NPIX - 1)) state_nxt = DRAIN;
            DRAIN:   if (ofm_valid_q && pix_out == PIX_W'(NPIX - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN, DRAIN: busy = 1'b1;
            DONE:       done = 1'b1;
            default:    ;
        endcase
    end

    // The ROM answers one cycle after weight_addr, so the beat and its flags are delayed to match.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt     <= '0;
            pix_in      <= '0;
            pix_out     <= '0;
            ifm_d       <= '0;
            vld_d       <= 1'b0;
            first_d     <= 1'b0;
            last_d      <= 1'b0;
            fin         <= 1'b0;
            ofm_valid_q <= 1'b0;
        end else begin
            ifm_d       <= bus.ifm;
            vld_d       <= beat;
            first_d     <= is_first;
            last_d      <= is_last;
            fin         <= vld_d && last_d;
            ofm_valid_q <= fin;
            if (state == IDLE && bus.start) begin
                tap_cnt <= '0;
                pix_in  <= '0;
                pix_out <= '0;
            end else begin
                if (beat) begin
                    tap_cnt <= is_last ? '0 : tap_cnt + TAP_W'(1);
                    if (is_last)
                        pix_in <= pix_in + PIX_W'(1);
                end
                if (ofm_valid_q)
                    pix_out <= pix_out + PIX_W'(1);
            end
        end
    end

    for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
        conv_mac_lane #(
            .WIDTH    (WIDTH),
            .FRAC_BITS(FRAC_BITS),
            .ACC_W    (ACC_W),
            .RELU_EN  (RELU_EN)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .beat  (vld_d),
            .first (first_d),
            .fin   (fin),
            .ifm   (ifm_d),
            .weight(bus.weights[g*WIDTH +: WIDTH]),
            .bias  (bus.bias[g*2*WIDTH +: 2*WIDTH]),
            .ofm   (ofm_lane[g])
        );
    end

    always_comb begin
        ofm_pk = '0;
        for (int i = 0; i < DSP_NO; i++)
            ofm_pk[i*WIDTH +: WIDTH] = ofm_lane[i];
    end

    assign bus.weight_addr = tap_cnt;
    assign bus.ofm         = ofm_pk;
    assign bus.ofm_valid   = ofm_valid_q;
    assign bus.busy        = busy;
    assign bus.done        = done;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Scoreboard bench: a ReLU and a linear engine share one stimulus stream; a monitor checks every
// ofm_valid and done against queued expectations.
module tb_conv_layer_engine;

    typedef struct {
        logic [15:0] r0, r1, l0, l1;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ifm_valid = 1'b0;
    logic [15:0] ifm = '0;
    logic [15:0] ifm_tap [2];
    logic [15:0] wtab [2][2];
    logic [31:0] b0, b1;
    int          cyc = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          done_seen = 0;
    exp_t        exp_q[$];
    int          done_q[$];

    conv_layer_engine_if #(.WIDTH(16), .DSP_NO(2), .ADDR_W(1)) bus_r ();
    conv_layer_engine_if #(.WIDTH(16), .DSP_NO(2), .ADDR_W(1)) bus_l ();

    conv_layer_engine #(.DSP_NO(2), .CHIN(2), .KERNEL_DIM(1), .WOUT(2), .WIDTH(16),
                        .FRAC_BITS(14), .RELU_EN(1))
        u_relu (.clk(clk), .rst(rst), .bus(bus_r));

    conv_layer_engine #(.DSP_NO(2), .CHIN(2), .KERNEL_DIM(1), .WOUT(2), .WIDTH(16),
                        .FRAC_BITS(14), .RELU_EN(0))
        u_lin (.clk(clk), .rst(rst), .bus(bus_l));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus_r.start = start;
    assign bus_r.ifm = ifm;
    assign bus_r.ifm_valid = ifm_valid;
    assign bus_r.bias = {b1, b0};
    assign bus_l.start = start;
    assign bus_l.ifm = ifm;
    assign bus_l.ifm_valid = ifm_valid;
    assign bus_l.bias = {b1, b0};

    // Synchronous weight ROMs, one per engine.
    always @(posedge clk) begin
        bus_r.weights <= {wtab[1][bus_r.weight_addr], wtab[0][bus_r.weight_addr]};
        bus_l.weights <= {wtab[1][bus_l.weight_addr], wtab[0][bus_l.weight_addr]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req)
            pass_cnt++;
        else
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clk) begin
        if (bus_r.ofm_valid === 1'b1 || bus_l.ofm_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_ofm_valid: actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("relu_valid", {31'd0, bus_r.ofm_valid}, 1);
                chk("lin_valid", {31'd0, bus_l.ofm_valid}, 1);
                chk("relu_lane0", {16'd0, bus_r.ofm[15:0]}, {16'd0, e.r0});
                chk("relu_lane1", {16'd0, bus_r.ofm[31:16]}, {16'd0, e.r1});
                chk("lin_lane0", {16'd0, bus_l.ofm[15:0]}, {16'd0, e.l0});
                chk("lin_lane1", {16'd0, bus_l.ofm[31:16]}, {16'd0, e.l1});
            end
        end
        if (bus_r.done === 1'b1 || bus_l.done === 1'b1) begin
            done_seen++;
            if (done_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_done: actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                chk("done_cycle", cyc, done_q.pop_front());
                chk("done_both", {30'd0, bus_r.done, bus_l.done}, 3);
            end
        end
    end

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        ifm_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds 4 pixels x 2 taps; optional stall between tap 0 and tap 1 of pixel 0 and an optional
    // start pulse (which must be ignored) on a given beat.
    task automatic feed(input int stall_len, input int start_beat,
                        input logic [15:0] r0, input logic [15:0] r1,
                        input logic [15:0] l0, input logic [15:0] l1);
        int   last_exp = 0;
        int   bi = 0;
        exp_t e;
        for (int p = 0; p < 4; p++) begin
            for (int t = 0; t < 2; t++) begin
                if (p == 0 && t == 1) begin
                    for (int s = 0; s < stall_len; s++) begin
                        chk("stall_addr_frozen", {31'd0, bus_r.weight_addr}, 1);
                        ifm_valid = 1'b0;
                        ifm = 16'h7fff;
                        @(negedge clk);
                    end
                end
                if (p == 1 && t == 0)
                    chk("busy_in_run", {30'd0, bus_r.busy, bus_l.busy}, 3);
                ifm_valid = 1'b1;
                ifm = ifm_tap[t];
                start = (bi == start_beat);
                if (t == 1) begin
                    e.r0 = r0; e.r1 = r1; e.l0 = l0; e.l1 = l1;
                    e.cyc = cyc + 3;
                    last_exp = e.cyc;
                    exp_q.push_back(e);
                end
                bi++;
                @(negedge clk);
            end
        end
        ifm_valid = 1'b0;
        start = 1'b0;
        done_q.push_back(last_exp + 1);
    endtask

    task automatic wait_done();
        int seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            if (bus_r.done === 1'b1)
                seen = 1;
            else
                @(negedge clk);
        end
        chk("done_within_bound", seen, 1);
    endtask

    task automatic set_uniform(input logic [15:0] px, input logic [15:0] w, input logic [31:0] bias1);
        ifm_tap[0] = px; ifm_tap[1] = px;
        wtab[0][0] = w; wtab[0][1] = w; wtab[1][0] = w; wtab[1][1] = w;
        b0 = 32'd0; b1 = bias1;
    endtask

    initial begin
        int seen_before;
        set_uniform(16'd8192, 16'd8192, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ofm_relu", bus_r.ofm, 0);
        chk("rst_ofm_lin", bus_l.ofm, 0);
        chk("rst_ofm_valid", {31'd0, bus_r.ofm_valid}, 0);
        chk("rst_busy", {31'd0, bus_r.busy}, 0);
        chk("rst_done", {31'd0, bus_r.done}, 0);
        chk("rst_weight_addr", {31'd0, bus_r.weight_addr}, 0);

        // nominal: 0.5 * 0.5 * 2 taps = 0.5
        start_run();
        feed(0, -1, 16'd8192, 16'd8192, 16'd8192, 16'd8192);
        wait_done();

        // positive saturation: 1.0 * 1.0 * 2 = 2.0 -> 32767
        set_uniform(16'd16384, 16'd16384, 32'd0);
        start_run();
        feed(0, -1, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
        wait_done();

        // negative saturation: -2.0 -> -32768 linear, 0 with ReLU
        set_uniform(16'hc000, 16'd16384, 32'd0);
        start_run();
        feed(0, -1, 16'h0000, 16'h0000, 16'h8000, 16'h8000);
        wait_done();

        // bias -2^28 on lane 1: 0.5 - 1.0 = -0.5
        set_uniform(16'd8192, 16'd8192, 32'hf000_0000);
        start_run();
        feed(0, -1, 16'd8192, 16'h0000, 16'd8192, 16'he000);
        wait_done();

        // 5-cycle stall between tap 0 and tap 1 of the first pixel
        set_uniform(16'd8192, 16'd8192, 32'd0);
        start_run();
        feed(5, -1, 16'd8192, 16'd8192, 16'd8192, 16'd8192);
        wait_done();

        // distinct taps/weights: lane0 = 0.25*1.0 - 0.125*0.5 + bias 100 lsb = 3172, lane1 = -0.25
        ifm_tap[0] = 16'd4096; ifm_tap[1] = 16'hf800;
        wtab[0][0] = 16'd16384; wtab[0][1] = 16'd8192;
        wtab[1][0] = 16'he000;  wtab[1][1] = 16'd16384;
        b0 = 32'h0019_0000; b1 = 32'd0;
        start_run();
        feed(0, -1, 16'h0c64, 16'h0000, 16'h0c64, 16'hf000);
        wait_done();

        // reset right after the 2nd output aborts the run
        set_uniform(16'd8192, 16'd8192, 32'd0);
        start_run();
        for (int b = 0; b < 7; b++) begin
            exp_t e;
            ifm_valid = 1'b1;
            ifm = ifm_tap[b % 2];
            if (b == 1 || b == 3) begin
                e.r0 = 16'd8192; e.r1 = 16'd8192; e.l0 = 16'd8192; e.l1 = 16'd8192;
                e.cyc = cyc + 3;
                exp_q.push_back(e);
            end
            if (b == 6)
                rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        ifm_valid = 1'b0;
        chk("abort_busy", {30'd0, bus_r.busy, bus_l.busy}, 0);
        chk("abort_ofm_relu", bus_r.ofm, 0);
        chk("abort_ofm_lin", bus_l.ofm, 0);
        seen_before = done_seen;
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_seen, seen_before);
        start_run();
        feed(0, -1, 16'd8192, 16'd8192, 16'd8192, 16'd8192);
        wait_done();

        // start pulsed mid-run is ignored; second run starts right after done
        start_run();
        feed(0, 3, 16'd8192, 16'd8192, 16'd8192, 16'd8192);
        wait_done();
        start_run();
        feed(0, -1, 16'd8192, 16'd8192, 16'd8192, 16'd8192);
        wait_done();

        repeat (10) @(negedge clk);
        chk("all_outputs_seen", exp_q.size(), 0);
        chk("all_dones_seen", done_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
